// File: rtl/sensor_sdk_axi_copy_pkg.sv
// Shared FSM states and AXI3 constants for the sensor SDK copy master.
package sensor_sdk_axi_copy_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_RD_ADDR = 3'd1;
    localparam state_t S_RD_DATA = 3'd2;
    localparam state_t S_WR_ADDR = 3'd3;
    localparam state_t S_WR_DATA = 3'd4;
    localparam state_t S_WR_RESP = 3'd5;
    localparam state_t S_DONE    = 3'd6;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'd2;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int PAGE_WORDS = 1024;

endpackage

// File: rtl/sensor_sdk_axi_copy_master_buffer.sv
// sensor_sdk_copy_burst_buffer: FWFT FIFO holding one read burst
// until it is written back out.
module sensor_sdk_copy_burst_buffer #(
    parameter int DEPTH   = 16,
    parameter int BW_DATA = 32
) (
    input  logic               clk,
    input  logic               rstnn,
    input  logic               clear,
    input  logic               push,
    input  logic [BW_DATA-1:0] push_data,
    input  logic               pop,
    output logic [BW_DATA-1:0] pop_data,
    output logic               empty,
    output logic               full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [BW_DATA-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sensor_sdk_axi_copy_master.sv
// AXI3 word-copy initiator: read burst into buffer, write it back out.
// Optional fill mode (no reads) under SENSOR_SDK_AXI_COPY_FILL_EN.
module sensor_sdk_axi_copy_master
    import sensor_sdk_axi_copy_pkg::*;
#(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 32,
    parameter int BW_AXI_TID = 4,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [BW_ADDR-1:0]    cmd_src,
    input  logic [BW_ADDR-1:0]    cmd_dst,
    input  logic [15:0]           cmd_num_word,
    input  logic                  cmd_fill,
    input  logic [BW_DATA-1:0]    cmd_pattern,
    output logic                  done,
    output logic                  error,
    output logic [BW_AXI_TID-1:0] sxawid,
    output logic [BW_ADDR-1:0]    sxawaddr,
    output logic [3:0]            sxawlen,
    output logic [2:0]            sxawsize,
    output logic [1:0]            sxawburst,
    output logic                  sxawvalid,
    input  logic                  sxawready,
    output logic [BW_AXI_TID-1:0] sxwid,
    output logic [BW_DATA-1:0]    sxwdata,
    output logic [BW_DATA/8-1:0]  sxwstrb,
    output logic                  sxwlast,
    output logic                  sxwvalid,
    input  logic                  sxwready,
    input  logic [BW_AXI_TID-1:0] sxbid,
    input  logic [1:0]            sxbresp,
    input  logic                  sxbvalid,
    output logic                  sxbready,
    output logic [BW_AXI_TID-1:0] sxarid,
    output logic [BW_ADDR-1:0]    sxaraddr,
    output logic [3:0]            sxarlen,
    output logic [2:0]            sxarsize,
    output logic [1:0]            sxarburst,
    output logic                  sxarvalid,
    input  logic                  sxarready,
    input  logic [BW_AXI_TID-1:0] sxrid,
    input  logic [BW_DATA-1:0]    sxrdata,
    input  logic [1:0]            sxrresp,
    input  logic                  sxrlast,
    input  logic                  sxrvalid,
    output logic                  sxrready
);

`ifdef SENSOR_SDK_AXI_COPY_FILL_EN
    localparam bit FILL_ON = 1'b1;
`else
    localparam bit FILL_ON = 1'b0;
`endif

    state_t             state;
    logic [BW_ADDR-1:0] src;
    logic [BW_ADDR-1:0] dst;
    logic [15:0]        remaining;
    logic               fill_q;
    logic [BW_DATA-1:0] pattern_q;
    logic               err_q;
    logic               rd_err;
    logic [4:0]         wcnt;
    logic [4:0]         beats;
    logic [3:0]         len;
    logic [10:0]        src_room;
    logic [10:0]        dst_room;
    logic               last_beat;
    logic               ar_on;
    logic               aw_on;
    logic               w_on;
    logic [BW_DATA-1:0] buf_head;
    logic               buf_empty;
    logic               buf_full;
    logic               accept;
    logic               unused_sig;

    // Burst never crosses a 4 KB page on either the read or write side.
    always_comb begin
        src_room = 11'(PAGE_WORDS) - {1'b0, src[11:2]};
        dst_room = 11'(PAGE_WORDS) - {1'b0, dst[11:2]};
        beats = (remaining > 16'(MAX_BURST)) ? 5'(MAX_BURST) : remaining[4:0];
        if (11'(beats) > src_room) beats = src_room[4:0];
        if (11'(beats) > dst_room) beats = dst_room[4:0];
    end

    assign len       = 4'(beats - 5'd1);
    assign last_beat = (wcnt == beats - 5'd1);
    assign accept    = (state == S_IDLE) && cmd_valid;
    assign ar_on     = (state == S_RD_ADDR);
    assign aw_on     = (state == S_WR_ADDR);
    assign w_on      = (state == S_WR_DATA);

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state     <= S_IDLE;
            src       <= '0;
            dst       <= '0;
            remaining <= '0;
            fill_q    <= 1'b0;
            pattern_q <= '0;
            err_q     <= 1'b0;
            rd_err    <= 1'b0;
            wcnt      <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (cmd_valid) begin
                    src       <= {cmd_src[BW_ADDR-1:2], 2'b00};
                    dst       <= {cmd_dst[BW_ADDR-1:2], 2'b00};
                    remaining <= cmd_num_word;
                    fill_q    <= cmd_fill & FILL_ON;
                    pattern_q <= cmd_pattern;
                    err_q     <= 1'b0;
                    rd_err    <= 1'b0;
                    wcnt      <= '0;
                    if (cmd_num_word == 16'd0) state <= S_DONE;
                    else if (cmd_fill & FILL_ON) state <= S_WR_ADDR;
                    else state <= S_RD_ADDR;
                end
                S_RD_ADDR: if (sxarready) state <= S_RD_DATA;
                S_RD_DATA: if (sxrvalid) begin
                    if (sxrresp != RESP_OKAY) rd_err <= 1'b1;
                    // A faulty read burst is drained but never written.
                    if (sxrlast) begin
                        rd_err <= 1'b0;
                        if (rd_err || sxrresp != RESP_OKAY) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_WR_ADDR;
                        end
                    end
                end
                S_WR_ADDR: if (sxawready) state <= S_WR_DATA;
                S_WR_DATA: if (sxwready) begin
                    if (last_beat) begin
                        wcnt  <= '0;
                        state <= S_WR_RESP;
                    end else begin
                        wcnt <= wcnt + 5'd1;
                    end
                end
                S_WR_RESP: if (sxbvalid) begin
                    src       <= src + BW_ADDR'({beats, 2'b00});
                    dst       <= dst + BW_ADDR'({beats, 2'b00});
                    remaining <= remaining - 16'(beats);
                    if (sxbresp != RESP_OKAY) err_q <= 1'b1;
                    if (remaining == 16'(beats) || sxbresp != RESP_OKAY)
                        state <= S_DONE;
                    else if (fill_q)
                        state <= S_WR_ADDR;
                    else
                        state <= S_RD_ADDR;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    sensor_sdk_copy_burst_buffer #(
        .DEPTH   (MAX_BURST),
        .BW_DATA (BW_DATA)
    ) u_buffer (
        .clk       (clk),
        .rstnn     (rstnn),
        .clear     (accept),
        .push      ((state == S_RD_DATA) && sxrvalid),
        .push_data (sxrdata),
        .pop       (w_on && sxwready && !fill_q),
        .pop_data  (buf_head),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    assign cmd_ready = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign error     = err_q;

    assign sxarid    = '0;
    assign sxarvalid = ar_on;
    assign sxaraddr  = ar_on ? src : '0;
    assign sxarlen   = ar_on ? len : '0;
    assign sxarsize  = ar_on ? SIZE_4B : '0;
    assign sxarburst = ar_on ? BURST_INCR : '0;
    assign sxrready  = (state == S_RD_DATA);

    assign sxawid    = '0;
    assign sxawvalid = aw_on;
    assign sxawaddr  = aw_on ? dst : '0;
    assign sxawlen   = aw_on ? len : '0;
    assign sxawsize  = aw_on ? SIZE_4B : '0;
    assign sxawburst = aw_on ? BURST_INCR : '0;

    assign sxwid    = '0;
    assign sxwvalid = w_on;
    assign sxwdata  = w_on ? (fill_q ? pattern_q : buf_head) : '0;
    assign sxwstrb  = w_on ? '1 : '0;
    assign sxwlast  = w_on && last_beat;
    assign sxbready = (state == S_WR_RESP);

    assign unused_sig = ^{sxrid, sxbid, cmd_src[1:0], cmd_dst[1:0],
                          buf_empty, buf_full};

endmodule
